cga_composite_encoder: RTL and testbench



---
 rtl/cga_pkg.sv | 35 +++
 rtl/cga_burst_timer.sv | 71 +++++++
 rtl/cga_composite_encoder.sv | 102 ++++++++++
 tb/tb_cga_composite_encoder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cga_pkg.sv
// cga_pkg -- shared constants, types and helpers for the CGA composite encoder.
//   Level/amplitude defaults, the 3-bit colour-index type, the per-colour
//   subcarrier phase-offset table, the burst FSM state enum and chroma_bit().
package cga_pkg;

  localparam int CGA_SYNC_LEVEL  = 0;
  localparam int CGA_BLANK_LEVEL = 32;
  localparam int CGA_LUMA_I      = 40;
  localparam int CGA_CHROMA_AMP  = 24;
  localparam int CGA_BURST_AMP   = 12;
  localparam int CGA_BURST_START = 56;
  localparam int CGA_BURST_LEN   = 72;

  typedef logic [2:0] cidx_t;

  // Phase (in 1/8 subcarrier cycles) where each colour's square wave goes high.
  // Entries 0 and 7 are unused: black and white carry no chroma.
  localparam logic [2:0] OFF [8] = '{3'd0, 3'd5, 3'd7, 3'd6, 3'd3, 3'd4, 3'd1, 3'd0};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } burst_st_e;

  // High half of the square wave: (p - OFF[c]) mod 8 < 4, i.e. bit 2 clear.
  function automatic logic chroma_bit(input cidx_t c, input logic [2:0] p);
    logic [2:0] d;
    d = p - OFF[c];
    if (c == 3'd0)      return 1'b0;
    else if (c == 3'd7) return 1'b1;
    else                return ~d[2];
  endfunction

endpackage

// File: rtl/cga_burst_timer.sv
// cga_burst_timer -- colour-burst window generator.
//   Detects the falling edge of (registered) hsync, waits BURST_START clocks,
//   then flags a BURST_LEN-clock burst window. Any sync aborts to IDLE.
// Ports:
//   clk, reset     video clock, synchronous active-high reset
//   hsync_i        registered horizontal sync
//   vsync_i        registered vertical sync
//   burst_win_o    high while the FSM is in BURST
module cga_burst_timer
  import cga_pkg::*;
#(
  parameter int BURST_START = CGA_BURST_START,
  parameter int BURST_LEN   = CGA_BURST_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic hsync_i,
  input  logic vsync_i,
  output logic burst_win_o
);

  burst_st_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        hs_prev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (hs_prev_q && !hsync_i) begin
          state_d = ST_WAIT;
          cnt_d   = 8'd0;
        end
      end
      ST_WAIT: begin
        if (hsync_i || vsync_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 8'(BURST_START - 1)) begin
          state_d = ST_BURST;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_BURST: begin
        if (hsync_i || vsync_i || cnt_q == 8'(BURST_LEN - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      hs_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hs_prev_q <= hsync_i;
    end
  end

  assign burst_win_o = (state_q == ST_BURST);

endmodule

// File: rtl/cga_composite_encoder.sv
// cga_composite_encoder -- RGBI to 7-bit composite sample encoder.
//   Two-stage pipeline: stage 1 registers inputs and the free-running
//   subcarrier phase; stage 2 selects sync / burst / active level.
// Ports:
//   clk, reset     video clock (8 samples per subcarrier cycle), sync reset
//   video[3:0]     {I,R,G,B} pixel, border already merged
//   hsync, vsync   active-high syncs
//   bw_mode        1 = no burst, no chroma
//   comp[6:0]      composite sample code
//   phase[2:0]     subcarrier phase of the sample on comp
//   burst_active   high while comp carries burst
module cga_composite_encoder
  import cga_pkg::*;
#(
  parameter int SYNC_LEVEL  = CGA_SYNC_LEVEL,
  parameter int BLANK_LEVEL = CGA_BLANK_LEVEL,
  parameter int LUMA_I      = CGA_LUMA_I,
  parameter int CHROMA_AMP  = CGA_CHROMA_AMP,
  parameter int BURST_AMP   = CGA_BURST_AMP,
  parameter int BURST_START = CGA_BURST_START,
  parameter int BURST_LEN   = CGA_BURST_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] video,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       bw_mode,
  output logic [6:0] comp,
  output logic [2:0] phase,
  output logic       burst_active
);

  logic [2:0] ph_q;
  logic [3:0] video1_q;
  logic       hs1_q, vs1_q, bw1_q;
  logic [2:0] ph1_q;
  logic       burst_win;

  logic [6:0] comp_q, comp_d;
  logic [2:0] phase_q;
  logic       burst_q, burst_d;

  logic       chr;
  logic [7:0] active_sum;
  logic [7:0] burst_sum;

  cga_burst_timer #(
    .BURST_START (BURST_START),
    .BURST_LEN   (BURST_LEN)
  ) u_burst (
    .clk         (clk),
    .reset       (reset),
    .hsync_i     (hs1_q),
    .vsync_i     (vs1_q),
    .burst_win_o (burst_win)
  );

  always_comb begin
    chr        = !bw1_q && chroma_bit(video1_q[2:0], ph1_q);
    active_sum = 8'(BLANK_LEVEL)
               + (video1_q[3] ? 8'(LUMA_I) : 8'd0)
               + (chr ? 8'(CHROMA_AMP) : 8'd0);
    // Burst uses colour 6's phase as the reference.
    burst_sum  = chroma_bit(3'd6, ph1_q) ? 8'(BLANK_LEVEL + BURST_AMP)
                                         : 8'(BLANK_LEVEL - BURST_AMP);
    // Flag qualified by sync so it tracks exactly what comp carries.
    burst_d    = burst_win && !bw1_q && !(hs1_q || vs1_q);
    if (hs1_q || vs1_q) comp_d = 7'(SYNC_LEVEL);
    else if (burst_d)   comp_d = burst_sum[6:0];
    else                comp_d = active_sum[6:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ph_q     <= 3'd0;
      video1_q <= 4'd0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      bw1_q    <= 1'b0;
      ph1_q    <= 3'd0;
      comp_q   <= 7'(BLANK_LEVEL);
      phase_q  <= 3'd0;
      burst_q  <= 1'b0;
    end else begin
      ph_q     <= ph_q + 3'd1;
      video1_q <= video;
      hs1_q    <= hsync;
      vs1_q    <= vsync;
      bw1_q    <= bw_mode;
      ph1_q    <= ph_q;
      comp_q   <= comp_d;
      phase_q  <= ph1_q;
      burst_q  <= burst_d;
    end
  end

  assign comp         = comp_q;
  assign phase        = phase_q;
  assign burst_active = burst_q;

endmodule

// File: tb/tb_cga_composite_encoder.sv
module tb_cga_composite_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] video;
  logic       hsync, vsync, bw_mode;
  logic [6:0] comp;
  logic [2:0] phase;
  logic       burst_active;

  int checks = 0;
  int errors = 0;
  int tcnt   = 0;   // edges since reset was last seen

  cga_composite_encoder dut (
    .clk          (clk),
    .reset        (reset),
    .video        (video),
    .hsync        (hsync),
    .vsync        (vsync),
    .bw_mode      (bw_mode),
    .comp         (comp),
    .phase        (phase),
    .burst_active (burst_active)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    if (reset) tcnt = 0;
    else       tcnt++;
    #1;
  endtask

  // Phase counter resets to 0 and sits two stages ahead of the phase output.
  function automatic logic [2:0] ephase(input int n);
    return (n >= 2) ? 3'(n - 2) : 3'd0;
  endfunction

  task automatic test_reset();
    reset = 1'b1; video = 4'hF; hsync = 1'b0; vsync = 1'b0; bw_mode = 1'b0;
    repeat (3) tick();
    checks++; if (comp !== 7'd32) begin errors++; $display("FAIL reset_comp: got %0d expected 32", comp); end
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    checks++; if (burst_active !== 1'b0) begin errors++; $display("FAIL reset_burst: got %0d expected 0", burst_active); end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (phase !== ephase(tcnt)) begin errors++; $display("FAIL phase_count[%0d]: got %0d expected %0d", i, phase, ephase(tcnt)); end
    end
  endtask

  task automatic test_luma();
    logic [3:0] vv [3];
    logic [6:0] ee [3];
    vv = '{4'h8, 4'h7, 4'h0};
    ee = '{7'd72, 7'd56, 7'd32};
    for (int k = 0; k < 3; k++) begin
      video = vv[k];
      repeat (2) tick();
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (comp !== ee[k]) begin errors++; $display("FAIL luma_v%0h: got %0d expected %0d", vv[k], comp, ee[k]); end
        tick();
      end
    end
  endtask

  task automatic test_chroma();
    logic [2:0] p;
    logic [6:0] e;
    video = 4'h1;
    repeat (2) tick();
    for (int i = 0; i < 16; i++) begin
      p = ephase(tcnt);
      e = (p == 3'd5 || p == 3'd6 || p == 3'd7 || p == 3'd0) ? 7'd56 : 7'd32;
      checks++;
      if (comp !== e) begin errors++; $display("FAIL chroma_blue p%0d: got %0d expected %0d", p, comp, e); end
      checks++;
      if (phase !== p) begin errors++; $display("FAIL chroma_phase: got %0d expected %0d", phase, p); end
      tick();
    end
  endtask

  task automatic test_bw_mode();
    logic [2:0] p;
    logic [6:0] e;
    video = 4'hE; bw_mode = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (comp !== 7'd72) begin errors++; $display("FAIL bw_yellow: got %0d expected 72", comp); end
      tick();
    end
    bw_mode = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 16; i++) begin
      p = ephase(tcnt);
      e = (p >= 3'd1 && p <= 3'd4) ? 7'd96 : 7'd72;
      checks++;
      if (comp !== e) begin errors++; $display("FAIL color_yellow p%0d: got %0d expected %0d", p, comp, e); end
      tick();
    end
    video = 4'h0;
    repeat (2) tick();
  endtask

  // One 40-clock hsync pulse; k counts clocks after the edge that samples the fall.
  task automatic test_burst(input logic bw);
    logic [2:0] p;
    logic [6:0] e;
    logic       eb;
    video = 4'h0; bw_mode = bw;
    hsync = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i >= 2) begin
        checks++;
        if (comp !== 7'd0) begin errors++; $display("FAIL sync_level: got %0d expected 0", comp); end
      end
    end
    hsync = 1'b0;
    for (int k = 0; k < 140; k++) begin
      tick();
      p  = ephase(tcnt);
      eb = !bw && (k >= 58) && (k < 130);
      if (k == 0)  e = 7'd0;
      else if (eb) e = (p >= 3'd1 && p <= 3'd4) ? 7'd44 : 7'd20;
      else         e = 7'd32;
      checks++;
      if (burst_active !== eb) begin errors++; $display("FAIL burst_flag bw%0d k%0d: got %0d expected %0d", bw, k, burst_active, eb); end
      checks++;
      if (comp !== e) begin errors++; $display("FAIL burst_comp bw%0d k%0d: got %0d expected %0d", bw, k, comp, e); end
    end
    bw_mode = 1'b0;
  endtask

  // Short hsync pulse, then run to 10 clocks into the burst.
  task automatic start_burst();
    video = 4'h0; bw_mode = 1'b0;
    hsync = 1'b1;
    repeat (5) tick();
    hsync = 1'b0;
    for (int k = 0; k <= 68; k++) tick();
    checks++;
    if (burst_active !== 1'b1) begin errors++; $display("FAIL burst_before_abort: got %0d expected 1", burst_active); end
  endtask

  task automatic test_abort_reset();
    start_burst();
    reset = 1'b1;
    tick();
    checks++; if (burst_active !== 1'b0) begin errors++; $display("FAIL rst_abort_flag: got %0d expected 0", burst_active); end
    checks++; if (comp !== 7'd32) begin errors++; $display("FAIL rst_abort_comp: got %0d expected 32", comp); end
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL rst_abort_phase: got %0d expected 0", phase); end
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if (burst_active !== 1'b0 || comp !== 7'd32) begin
        errors++; $display("FAIL rst_no_resume[%0d]: got flag %0d comp %0d expected 0/32", i, burst_active, comp);
      end
    end
  endtask

  task automatic test_abort_hsync();
    start_burst();
    hsync = 1'b1;
    tick();
    checks++; if (burst_active !== 1'b1) begin errors++; $display("FAIL hs_abort_latency: got %0d expected 1", burst_active); end
    for (int i = 0; i < 80; i++) begin
      tick();
      checks++;
      if (burst_active !== 1'b0 || comp !== 7'd0) begin
        errors++; $display("FAIL hs_abort[%0d]: got flag %0d comp %0d expected 0/0", i, burst_active, comp);
      end
    end
    hsync = 1'b0;
    for (int k = 0; k < 58; k++) tick();
    checks++; if (burst_active !== 1'b0) begin errors++; $display("FAIL hs_restart_early: got %0d expected 0", burst_active); end
    tick();
    checks++; if (burst_active !== 1'b1) begin errors++; $display("FAIL hs_restart: got %0d expected 1", burst_active); end
  endtask

  initial begin
    test_reset();
    test_luma();
    test_chroma();
    test_bw_mode();
    test_burst(1'b0);
    test_burst(1'b1);
    test_abort_reset();
    test_abort_hsync();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
